// File: rtl/fnd_pkg.sv
// Shared constants and types for the stopwatch 7-segment display controller.
// Fonts are active-low with bit7 = dp and bits6:0 = segments g..a.
package fnd_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [7:0] FONT_0     = 8'hC0;
   localparam logic [7:0] FONT_1     = 8'hF9;
   localparam logic [7:0] FONT_2     = 8'hA4;
   localparam logic [7:0] FONT_3     = 8'hB0;
   localparam logic [7:0] FONT_4     = 8'h99;
   localparam logic [7:0] FONT_5     = 8'h92;
   localparam logic [7:0] FONT_6     = 8'h82;
   localparam logic [7:0] FONT_7     = 8'hF8;
   localparam logic [7:0] FONT_8     = 8'h80;
   localparam logic [7:0] FONT_9     = 8'h90;
   localparam logic [7:0] FONT_BLANK = 8'hFF;
   localparam logic [7:0] DP_MASK    = 8'h7F;

   localparam logic MODE_SEC_MS   = 1'b0;
   localparam logic MODE_HOUR_MIN = 1'b1;

   typedef logic [3:0] digit_t;

   typedef struct packed {
      logic [6:0] ms;
      logic [5:0] s;
      logic [5:0] m;
      logic [4:0] h;
      logic       mode;
   } snap_t;

endpackage

// File: rtl/stopwatch_fnd_ctrl_if.sv
// Counter inputs, mode switch and display outputs of the display controller.
// The datapath/bench side uses master; the controller uses slave.
interface stopwatch_fnd_ctrl_if;

   logic [6:0] ms_counter;
   logic [5:0] s_counter;
   logic [5:0] m_counter;
   logic [4:0] h_counter;
   logic       i_sw_mode;
   logic [3:0] fnd_comm;
   logic [7:0] fnd_font;

   modport master (
      output ms_counter, s_counter, m_counter, h_counter, i_sw_mode,
      input  fnd_comm, fnd_font
   );

   modport slave (
      input  ms_counter, s_counter, m_counter, h_counter, i_sw_mode,
      output fnd_comm, fnd_font
   );

endinterface

// File: rtl/fnd_font_decoder.sv
// Combinational digit -> active-low 7-segment font; values above 9 are blank.
// The dp flag clears bit7 regardless of the digit value.
module fnd_font_decoder
   import fnd_pkg::*;
(
   input  digit_t      digit_i,
   input  logic        dp_i,
   output logic [7:0]  font_o
);

   logic [7:0] base;

   always_comb begin
      base = FONT_BLANK;
      case (digit_i)
         4'd0:    base = FONT_0;
         4'd1:    base = FONT_1;
         4'd2:    base = FONT_2;
         4'd3:    base = FONT_3;
         4'd4:    base = FONT_4;
         4'd5:    base = FONT_5;
         4'd6:    base = FONT_6;
         4'd7:    base = FONT_7;
         4'd8:    base = FONT_8;
         4'd9:    base = FONT_9;
         default: base = FONT_BLANK;
      endcase
      font_o = dp_i ? (base & DP_MASK) : base;
   end

endmodule

// File: rtl/stopwatch_fnd_ctrl.sv
// Time-multiplexed 4-digit display of SS.ms or HH.MM from a per-frame snapshot.
// Outputs update one cycle after each scan tick; the snapshot refreshes only on the 3->0 digit wrap.
module stopwatch_fnd_ctrl
   import fnd_pkg::*;
#(
   parameter int SCAN_DIV = 100_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   stopwatch_fnd_ctrl_if.slave  bus
);

   localparam int            CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
   localparam logic [1:0]    IDX_LAST = 2'(NUM_DIGITS - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick;
   logic [1:0]    idx_q, idx_d;
   logic          mode_meta_q, mode_sync_q;
   snap_t         snap_q, snap_d;
   logic          upd_q;
   logic [3:0]    comm_q, comm_d;
   logic [7:0]    font_q, font_d;

   logic [6:0]    lo_val, hi_val;
   digit_t        digit;
   logic          dp;
   logic [7:0]    font;

   assign tick = (cnt_q == DIV_LAST);

   always_comb begin
      cnt_d  = tick ? '0 : cnt_q + CW'(1);
      idx_d  = idx_q;
      snap_d = snap_q;
      if (tick) begin
         idx_d = idx_q + 2'd1;
         if (idx_q == IDX_LAST) begin
            snap_d.ms   = bus.ms_counter;
            snap_d.s    = bus.s_counter;
            snap_d.m    = bus.m_counter;
            snap_d.h    = bus.h_counter;
            snap_d.mode = mode_sync_q;
         end
      end
   end

   // Low pair is the two rightmost digits, high pair the two leftmost.
   always_comb begin
      lo_val = snap_q.ms;
      hi_val = {1'b0, snap_q.s};
      if (snap_q.mode == MODE_HOUR_MIN) begin
         lo_val = {1'b0, snap_q.m};
         hi_val = {2'b00, snap_q.h};
      end
      case (idx_q)
         2'd0:    digit = digit_t'(lo_val % 7'd10);
         2'd1:    digit = digit_t'(lo_val / 7'd10);
         2'd2:    digit = digit_t'(hi_val % 7'd10);
         default: digit = digit_t'(hi_val / 7'd10);
      endcase
      dp = 1'b0;
      if (idx_q == 2'd2) begin
         dp = (snap_q.mode == MODE_HOUR_MIN) ? ~snap_q.s[0] : (snap_q.ms < 7'd50);
      end
   end

   fnd_font_decoder u_dec (
      .digit_i (digit),
      .dp_i    (dp),
      .font_o  (font)
   );

   always_comb begin
      comm_d = comm_q;
      font_d = font_q;
      if (upd_q) begin
         comm_d = ~(4'b0001 << idx_q);
         font_d = font;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         idx_q       <= IDX_LAST;
         mode_meta_q <= 1'b0;
         mode_sync_q <= 1'b0;
         snap_q      <= '0;
         upd_q       <= 1'b0;
         comm_q      <= 4'b1111;
         font_q      <= FONT_BLANK;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         mode_meta_q <= bus.i_sw_mode;
         mode_sync_q <= mode_meta_q;
         snap_q      <= snap_d;
         upd_q       <= tick;
         comm_q      <= comm_d;
         font_q      <= font_d;
      end
   end

   assign bus.fnd_comm = comm_q;
   assign bus.fnd_font = font_q;

endmodule

// File: tb/tb_stopwatch_fnd_ctrl.sv
// Bench for stopwatch_fnd_ctrl with SCAN_DIV=4: directed frames followed by random counter/mode traffic,
// compared every cycle against a frame-level model of the display.
module tb_stopwatch_fnd_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   stopwatch_fnd_ctrl_if bus ();

   stopwatch_fnd_ctrl #(.SCAN_DIV(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   bit   mode_at [8192];
   int   sms, ss, sm, sh;
   bit   smode;
   logic [3:0] exp_comm;
   logic [7:0] exp_font;
   logic [7:0] font_tab [16];

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic set_inputs(input int ms, input int s, input int m, input int h, input bit mode);
      bus.ms_counter = 7'(ms);
      bus.s_counter  = 6'(s);
      bus.m_counter  = 6'(m);
      bus.h_counter  = 5'(h);
      bus.i_sw_mode  = mode;
   endtask

   // Digit d of the frame snapshot: rightmost pair from ms or minutes, leftmost from seconds or hours.
   function automatic logic [7:0] model_font(input int d);
      int lo, hi, v;
      bit dot;
      logic [7:0] f;
      lo = smode ? sm : sms;
      hi = smode ? sh : ss;
      case (d)
         0:       v = lo % 10;
         1:       v = lo / 10;
         2:       v = hi % 10;
         default: v = hi / 10;
      endcase
      dot = (d == 2) && (smode ? (ss % 2 == 0) : (sms < 50));
      f = (v <= 9) ? font_tab[v] : 8'hFF;
      if (dot) f = f & 8'h7F;
      return f;
   endfunction

   // Timing after reset release: snapshot at edge 4+16f (mode sampled 2 edges earlier),
   // new slot on the outputs at edge 5+4k showing digit k mod 4.
   task automatic run_cycles(input int n, input bit rnd);
      int d;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         cyc++;
         mode_at[cyc] = bus.i_sw_mode;
         if (cyc >= 4 && (cyc - 4) % 16 == 0) begin
            sms   = int'(bus.ms_counter);
            ss    = int'(bus.s_counter);
            sm    = int'(bus.m_counter);
            sh    = int'(bus.h_counter);
            smode = mode_at[cyc-2];
         end
         if (cyc >= 5 && (cyc - 5) % 4 == 0) begin
            d = ((cyc - 5) / 4) % 4;
            exp_comm    = 4'b1111;
            exp_comm[d] = 1'b0;
            exp_font    = model_font(d);
         end
         @(negedge clk);
         check("comm", {4'h0, bus.fnd_comm}, {4'h0, exp_comm});
         check("font", bus.fnd_font, exp_font);
         if (rnd) begin
            if ($urandom_range(7) == 0) begin
               bus.ms_counter = ($urandom_range(3) == 0) ? 7'($urandom_range(127)) : 7'($urandom_range(99));
               bus.s_counter  = 6'($urandom_range(59));
               bus.m_counter  = 6'($urandom_range(59));
               bus.h_counter  = 5'($urandom_range(23));
            end
            if ($urandom_range(31) == 0) bus.i_sw_mode = ~bus.i_sw_mode;
         end
      end
   endtask

   task automatic restart_model();
      cyc      = 0;
      exp_comm = 4'b1111;
      exp_font = 8'hFF;
   endtask

   initial begin
      font_tab[0] = 8'hC0; font_tab[1] = 8'hF9; font_tab[2] = 8'hA4; font_tab[3] = 8'hB0;
      font_tab[4] = 8'h99; font_tab[5] = 8'h92; font_tab[6] = 8'h82; font_tab[7] = 8'hF8;
      font_tab[8] = 8'h80; font_tab[9] = 8'h90;
      for (int i = 10; i < 16; i++) font_tab[i] = 8'hFF;

      // Reset held for 3 cycles: display dark.
      set_inputs(37, 42, 0, 0, 1'b0);
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_comm", {4'h0, bus.fnd_comm}, 8'h0F);
         check("rst_font", bus.fnd_font, 8'hFF);
      end
      rst_n = 1'b1;
      restart_model();

      // Frame 0: SS.ms with ms=37 s=42 (F8, B0, 24, 99).
      run_cycles(20, 1'b0);
      // ms=75: dot off from the frame captured at edge 36.
      set_inputs(75, 42, 0, 0, 1'b0);
      run_cycles(16, 1'b0);
      // HH.MM with h=23 m=05 s=10 (92, C0, 30, A4).
      set_inputs(75, 10, 5, 23, 1'b1);
      run_cycles(22, 1'b0);
      // Mode flipped while idx=1: current frame stays HH.MM.
      set_inputs(75, 10, 5, 23, 1'b0);
      run_cycles(16, 1'b0);
      set_inputs(37, 42, 5, 23, 1'b0);
      run_cycles(16, 1'b0);
      // ms 37->38 while idx=1: visible only from the next frame's d0.
      set_inputs(38, 42, 5, 23, 1'b0);
      run_cycles(16, 1'b0);
      // Out-of-range ms=120: d1 blank, d0 = 0.
      set_inputs(120, 42, 5, 23, 1'b0);
      run_cycles(38, 1'b0);

      // Asynchronous reset mid-frame blanks the outputs before the next edge.
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_comm", {4'h0, bus.fnd_comm}, 8'h0F);
      check("arst_font", bus.fnd_font, 8'hFF);
      @(negedge clk);
      check("arst_hold_comm", {4'h0, bus.fnd_comm}, 8'h0F);
      set_inputs(12, 34, 56, 7, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      restart_model();

      run_cycles(800, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
